unidade_relocacao: RTL

Parametrised address-relocation unit for the processor's partitioned memories. It translates a process-relative address into a physical address using a programmable base/limit pair per process. It replaces the fixed per-process offset adder with a two-stage valid/ready pipeline that adds limit checking and fault capture. One instance sits in front of the instruction memory and one in front of the data memory.

---
 rtl/unidade_relocacao.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/unidade_relocacao.sv
// ============================================================================
// Module   : unidade_relocacao
// Brief    : Two-stage base/limit address relocation with fault capture.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module unidade_relocacao #(
    parameter int PID_W    = 2,
    parameter int ADDR_W   = 9,
    parameter int DEF_SIZE = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [PID_W-1:0]  cfg_id,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PID_W-1:0]  in_pid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_fault,
    output logic              fault_flag,
    output logic [PID_W-1:0]  fault_pid,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [7:0]        fault_count,
    input  logic              fault_clr
);

    localparam int N_PROC = 2**PID_W;

    logic [ADDR_W-1:0] base_q  [N_PROC];
    logic [ADDR_W-1:0] limit_q [N_PROC];

    logic              s1_valid_q;
    logic [PID_W-1:0]  s1_pid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [ADDR_W-1:0] s1_base_q;
    logic [ADDR_W-1:0] s1_limit_q;

    logic              s2_valid_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              s2_fault_q;

    logic              flag_q, flag_d;
    logic [PID_W-1:0]  fpid_q, fpid_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [7:0]        fcnt_q, fcnt_d;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;
    logic              load_s2;
    logic [ADDR_W:0]   sum;
    logic              fault_now;
    logic              capture;

    assign s2_adv    = !s2_valid_q | out_ready;
    assign s1_adv    = !s1_valid_q | s2_adv;
    assign accept    = in_valid & s1_adv;
    assign load_s2   = s1_valid_q & s2_adv;

    // Carry out of the ADDR_W-bit add means the partition wraps past memory top.
    assign sum       = {1'b0, s1_base_q} + {1'b0, s1_addr_q};
    assign fault_now = (s1_addr_q >= s1_limit_q) | sum[ADDR_W];
    assign capture   = load_s2 & fault_now;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PROC; i++) begin
                base_q[i]  <= ADDR_W'(i * DEF_SIZE);
                limit_q[i] <= ADDR_W'(DEF_SIZE);
            end
        end else if (cfg_we) begin
            base_q[cfg_id]  <= cfg_base;
            limit_q[cfg_id] <= cfg_limit;
        end
    end

    // Stage 1 samples the table before any same-edge config write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_pid_q   <= '0;
            s1_addr_q  <= '0;
            s1_base_q  <= '0;
            s1_limit_q <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (accept) begin
                s1_pid_q   <= in_pid;
                s1_addr_q  <= in_addr;
                s1_base_q  <= base_q[in_pid];
                s1_limit_q <= limit_q[in_pid];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_fault_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (load_s2) begin
                s2_addr_q  <= fault_now ? '0 : sum[ADDR_W-1:0];
                s2_fault_q <= fault_now;
            end
        end
    end

    // A capture in the same cycle as a clear restarts the record with this fault.
    always_comb begin
        flag_d  = flag_q;
        fpid_d  = fpid_q;
        faddr_d = faddr_q;
        fcnt_d  = fcnt_q;
        if (fault_clr) begin
            flag_d  = 1'b0;
            fpid_d  = '0;
            faddr_d = '0;
            fcnt_d  = '0;
        end
        if (capture) begin
            if (!flag_q || fault_clr) begin
                flag_d  = 1'b1;
                fpid_d  = s1_pid_q;
                faddr_d = s1_addr_q;
            end
            if (fault_clr) begin
                fcnt_d = 8'd1;
            end else if (fcnt_q != 8'hFF) begin
                fcnt_d = fcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag_q  <= 1'b0;
            fpid_q  <= '0;
            faddr_q <= '0;
            fcnt_q  <= '0;
        end else begin
            flag_q  <= flag_d;
            fpid_q  <= fpid_d;
            faddr_q <= faddr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign in_ready    = s1_adv;
    assign out_valid   = s2_valid_q;
    assign out_addr    = s2_addr_q;
    assign out_fault   = s2_fault_q;
    assign fault_flag  = flag_q;
    assign fault_pid   = fpid_q;
    assign fault_addr  = faddr_q;
    assign fault_count = fcnt_q;

endmodule

`default_nettype wire
